// File: rtl/chd_ctrl_n.sv
// Charge/discharge sequencer: synchronised start edge -> CHARGE -> RUN -> DONE, with per-channel discharge, timeout and overrun flags.
// Start edge reaches outputs SYNC_STAGES+1 edges after i_start is first sampled high; outputs are flops or state decodes.
module chd_ctrl_n #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CHARGE_CYCLES = 8,
    parameter int DIS_TIMEOUT   = 1000,
    parameter int CNT_W         = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [N_CH-1:0] i_reset_ch,
    input  logic [N_CH-1:0] i_ch_en,
    output logic            o_first_charge,
    output logic [N_CH-1:0] o_discharge,
    output logic            o_startcounter,
    output logic            o_busy,
    output logic [N_CH-1:0] o_timeout,
    output logic            o_overrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_CHARGE, ST_RUN, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(DIS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                       state_q, state_d;
    logic [SYNC_STAGES-1:0]       sync_q, vld_q;
    logic                         hist_q, arm_q;
    logic                         start_edge, start_acc, chg_done;
    logic [CNT_W-1:0]             chg_cnt_q, chg_cnt_d;
    logic [N_CH-1:0][CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [N_CH-1:0]              disc_q, disc_d, tmo_q, tmo_d, to_hit;
    logic                         ovr_q, ovr_d;

    // vld_q marks which sync stages hold real samples; arm_q blocks a start edge
    // until a genuine low has been seen since reset, so a held i_start cannot restart.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
            vld_q  <= '0;
            hist_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_start};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            hist_q <= sync_q[SYNC_STAGES-1];
            if (vld_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                arm_q <= 1'b1;
            end
        end
    end

    assign start_edge = arm_q & sync_q[SYNC_STAGES-1] & ~hist_q;
    assign start_acc  = start_edge && (state_q == ST_IDLE);
    assign chg_done   = (state_q == ST_CHARGE) && (chg_cnt_q == CHG_LAST);

    always_comb begin
        disc_d    = disc_q;
        tmo_d     = tmo_q;
        ovr_d     = ovr_q;
        chg_cnt_d = chg_cnt_q;
        to_cnt_d  = to_cnt_q;
        to_hit    = '0;
        if (start_acc) begin
            disc_d    = i_ch_en;
            tmo_d     = '0;
            chg_cnt_d = '0;
        end
        if (state_q == ST_CHARGE && chg_cnt_q != CNT_MAX) begin
            chg_cnt_d = chg_cnt_q + CNT_W'(1);
        end
        if (chg_done) begin
            to_cnt_d = '0;
        end
        if (state_q == ST_RUN) begin
            for (int k = 0; k < N_CH; k++) begin
                if (disc_q[k]) begin
                    if (DIS_TIMEOUT != 0 && to_cnt_q[k] == TO_LAST) begin
                        to_hit[k] = 1'b1;
                    end
                    if (to_cnt_q[k] != CNT_MAX) begin
                        to_cnt_d[k] = to_cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
        // A channel reset on the timeout edge wins and leaves no timeout flag.
        disc_d = disc_d & ~to_hit & ~i_reset_ch;
        tmo_d  = tmo_d | (to_hit & ~i_reset_ch);
        if (start_edge && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_edge) state_d = ST_CHARGE;
            ST_CHARGE: if (chg_done) state_d = ST_RUN;
            ST_RUN:    if (disc_d == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            disc_q    <= '0;
            tmo_q     <= '0;
            ovr_q     <= 1'b0;
            chg_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            disc_q    <= disc_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
            chg_cnt_q <= chg_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        o_first_charge = (state_q == ST_CHARGE);
        o_startcounter = (state_q == ST_RUN);
        o_busy         = (state_q != ST_IDLE);
        o_discharge    = disc_q;
        o_timeout      = tmo_q;
        o_overrun      = ovr_q;
    end

endmodule

// File: tb/tb_chd_ctrl_n.sv
// Bench for chd_ctrl_n: directed table, hand-written reset sequence, then random stimulus against a phase-level model.
module tb_chd_ctrl_n;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int CC  = 8;
    localparam int TO  = 5;
    localparam int CW  = 16;

    logic           i_clk, i_reset, i_start;
    logic [NCH-1:0] i_reset_ch, i_ch_en;
    logic           o_first_charge, o_startcounter, o_busy, o_overrun;
    logic [NCH-1:0] o_discharge, o_timeout;

    chd_ctrl_n #(
        .N_CH(NCH), .SYNC_STAGES(SS), .CHARGE_CYCLES(CC), .DIS_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_reset_ch(i_reset_ch), .i_ch_en(i_ch_en),
        .o_first_charge(o_first_charge), .o_discharge(o_discharge),
        .o_startcounter(o_startcounter), .o_busy(o_busy),
        .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {o_first_charge, o_discharge, o_startcounter, o_busy, o_timeout, o_overrun};
    endfunction

    // Reference model: sequence phases with elapsed-cycle counts, start detected as
    // a 0->1 pair of post-reset samples seen SYNC_STAGES edges late.
    typedef enum {P_IDLE, P_CHARGE, P_RUN, P_DONE} phase_e;
    phase_e     m_phase;
    int         m_chg;
    int         m_age [NCH];
    logic [3:0] m_disc, m_tmo;
    logic       m_ovr;
    bit         m_q[$];
    int         m_n;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_chg   = 0;
        m_disc  = '0;
        m_tmo   = '0;
        m_ovr   = 1'b0;
        m_n     = 0;
        m_q.delete();
        for (int k = 0; k < NCH; k++) m_age[k] = 0;
    endtask

    task automatic model_edge();
        bit         se;
        logic [3:0] rc;
        if (i_reset) begin
            model_reset();
            return;
        end
        rc = i_reset_ch;
        m_q.push_back(i_start);
        m_n++;
        if (m_q.size() > SS + 2) m_q.delete(0);
        se = (m_n >= SS + 2) && m_q[1] && !m_q[0];
        case (m_phase)
            P_IDLE: begin
                if (se) begin
                    m_phase = P_CHARGE;
                    m_chg   = 0;
                    m_disc  = i_ch_en;
                    m_tmo   = '0;
                end
                m_disc &= ~rc;
            end
            P_CHARGE: begin
                m_chg++;
                m_disc &= ~rc;
                if (se) m_ovr = 1'b1;
                if (m_chg == CC) begin
                    m_phase = P_RUN;
                    for (int k = 0; k < NCH; k++) m_age[k] = 0;
                end
            end
            P_RUN: begin
                for (int k = 0; k < NCH; k++) begin
                    if (m_disc[k]) begin
                        m_age[k]++;
                        if (TO != 0 && m_age[k] == TO) begin
                            m_disc[k] = 1'b0;
                            if (!rc[k]) m_tmo[k] = 1'b1;
                        end
                    end
                end
                m_disc &= ~rc;
                if (se) m_ovr = 1'b1;
                if (m_disc == 4'h0) m_phase = P_DONE;
            end
            default: begin
                m_disc &= ~rc;
                if (se) m_ovr = 1'b1;
                m_phase = P_IDLE;
            end
        endcase
    endtask

    function automatic logic [11:0] model_vec();
        return {m_phase == P_CHARGE, m_disc, m_phase == P_RUN, m_phase != P_IDLE, m_tmo, m_ovr};
    endfunction

    task automatic step(input string name);
        @(posedge i_clk);
        model_edge();
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    typedef struct {
        logic       start;
        logic [3:0] rc;
        logic [3:0] en;
        int         ncyc;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [3:0] rc, input logic [3:0] en, input int n,
                                input logic fc, input logic [3:0] d, input logic sc, input logic b,
                                input logic [3:0] t, input logic o);
        vec_t v;
        v.start = s;
        v.rc    = rc;
        v.en    = en;
        v.ncyc  = n;
        v.exp   = {fc, d, sc, b, t, o};
        return v;
    endfunction

    vec_t tbl [29];

    initial begin
        //            start rc    en    n   fc d     sc b  tmo   ovr
        tbl[0]  = mk(1, 4'h0, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 0);
        tbl[1]  = mk(1, 4'h0, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 0);
        tbl[2]  = mk(1, 4'h0, 4'hF, 1, 1, 4'hF, 0, 1, 4'h0, 0);
        tbl[3]  = mk(0, 4'h0, 4'hF, 7, 1, 4'hF, 0, 1, 4'h0, 0);
        tbl[4]  = mk(0, 4'h0, 4'hF, 1, 0, 4'hF, 1, 1, 4'h0, 0);
        tbl[5]  = mk(0, 4'h1, 4'hF, 1, 0, 4'hE, 1, 1, 4'h0, 0);
        tbl[6]  = mk(0, 4'h2, 4'hF, 1, 0, 4'hC, 1, 1, 4'h0, 0);
        tbl[7]  = mk(0, 4'h4, 4'hF, 1, 0, 4'h8, 1, 1, 4'h0, 0);
        tbl[8]  = mk(0, 4'h8, 4'hF, 1, 0, 4'h0, 0, 1, 4'h0, 0);
        tbl[9]  = mk(0, 4'h0, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 0);
        tbl[10] = mk(1, 4'h0, 4'hF, 3, 1, 4'hF, 0, 1, 4'h0, 0);
        tbl[11] = mk(0, 4'h0, 4'hF, 8, 0, 4'hF, 1, 1, 4'h0, 0);
        tbl[12] = mk(0, 4'h0, 4'hF, 4, 0, 4'hF, 1, 1, 4'h0, 0);
        tbl[13] = mk(0, 4'h0, 4'hF, 1, 0, 4'h0, 0, 1, 4'hF, 0);
        tbl[14] = mk(0, 4'h0, 4'hF, 1, 0, 4'h0, 0, 0, 4'hF, 0);
        tbl[15] = mk(1, 4'h1, 4'h5, 3, 1, 4'h4, 0, 1, 4'h0, 0);
        tbl[16] = mk(0, 4'h0, 4'h5, 8, 0, 4'h4, 1, 1, 4'h0, 0);
        tbl[17] = mk(1, 4'h0, 4'h5, 3, 0, 4'h4, 1, 1, 4'h0, 1);
        tbl[18] = mk(0, 4'h0, 4'h5, 2, 0, 4'h0, 0, 1, 4'h4, 1);
        tbl[19] = mk(0, 4'h0, 4'h5, 1, 0, 4'h0, 0, 0, 4'h4, 1);
        tbl[20] = mk(1, 4'h0, 4'h0, 3, 1, 4'h0, 0, 1, 4'h0, 1);
        tbl[21] = mk(0, 4'h0, 4'h0, 8, 0, 4'h0, 1, 1, 4'h0, 1);
        tbl[22] = mk(0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 1, 4'h0, 1);
        tbl[23] = mk(0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 4'h0, 1);
        tbl[24] = mk(1, 4'h0, 4'h3, 3, 1, 4'h3, 0, 1, 4'h0, 1);
        tbl[25] = mk(0, 4'h0, 4'h3, 8, 0, 4'h3, 1, 1, 4'h0, 1);
        tbl[26] = mk(0, 4'h0, 4'h3, 4, 0, 4'h3, 1, 1, 4'h0, 1);
        tbl[27] = mk(0, 4'h1, 4'h3, 1, 0, 4'h0, 0, 1, 4'h2, 1);
        tbl[28] = mk(0, 4'h0, 4'h3, 1, 0, 4'h0, 0, 0, 4'h2, 1);

        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_reset_ch = '0;
        i_ch_en    = '0;
        model_reset();
        #1 i_reset = 1'b1;
        #1 check("reset_state", dut_vec(), 12'h000);
        repeat (2) @(posedge i_clk);
        #3 i_reset = 1'b0;
        repeat (6) step("idle");

        for (int i = 0; i < 29; i++) begin
            i_start    = tbl[i].start;
            i_reset_ch = tbl[i].rc;
            i_ch_en    = tbl[i].en;
            for (int c = 0; c < tbl[i].ncyc; c++) step($sformatf("row%0d_cyc%0d", i, c));
            check($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // Async reset mid-RUN with i_start held high: no restart until it toggles.
        i_ch_en    = 4'hF;
        i_reset_ch = '0;
        i_start    = 1'b1;
        repeat (13) step("r38_seq");
        check("r38_in_run", 12'(o_startcounter), 12'd1);
        #2 i_reset = 1'b1;
        model_reset();
        #1 check("r38_async_clear", dut_vec(), 12'h000);
        step("r38_hold");
        #2 i_reset = 1'b0;
        repeat (20) step("r38_held_high");
        check("r38_no_restart", 12'(o_busy), 12'd0);
        i_start = 1'b0;
        repeat (3) step("r38_low");
        i_start = 1'b1;
        repeat (3) step("r38_rise");
        check("r38_restart", 12'(o_first_charge), 12'd1);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) i_start = ~i_start;
            if ($urandom_range(0, 15) == 0) i_ch_en = 4'($urandom);
            i_reset_ch = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 3) != 0) i_reset_ch = '0;
            step("rand");
            if ($urandom_range(0, 199) == 0) begin
                #2 i_reset = 1'b1;
                model_reset();
                #1 check("rand_async_rst", dut_vec(), model_vec());
                step("rand_rst_hold");
                #2 i_reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
